// File: rtl/issue_scheduler_pkg.sv
// ----------------------------------------------------------------------------
// issue_scheduler_pkg
// Shared definitions for the issue and execute stages: functional-unit
// encodings and the fixed writeback latency of each unit, measured from the
// cycle an instruction is accepted for issue to the cycle it writes back.
// ----------------------------------------------------------------------------
package issue_scheduler_pkg;

  typedef enum logic [1:0] {
    FU_NONE = 2'd0,
    FU_X    = 2'd1,   // ALU
    FU_M    = 2'd2,   // memory
    FU_Y    = 2'd3    // multiply
  } fu_e;

  localparam int LAT_X = 2;
  localparam int LAT_M = 3;
  localparam int LAT_Y = 5;

  // Depth of the writeback-port reservation window (longest latency).
  localparam int RESV_DEPTH = 5;

endpackage : issue_scheduler_pkg

// File: rtl/issue_scoreboard.sv
// ----------------------------------------------------------------------------
// issue_scoreboard
// 32-entry pending-write bitmap. A set bit means a register has an
// outstanding write in flight. Register 0 is hard-wired ready.
//
// Ports:
//   clock, reset             clock and synchronous active-high reset
//   set_en / set_reg         mark set_reg pending from next cycle
//   clr_en / clr_reg         clear clr_reg from next cycle (set wins on clash)
//   rd_a_reg / a_busy        source A lookup
//   rd_b_reg / b_busy        source B lookup
//   waw_reg / waw_busy       destination lookup for write-after-write checks
// ----------------------------------------------------------------------------
module issue_scoreboard (
  input  logic       clock,
  input  logic       reset,
  input  logic       set_en,
  input  logic [4:0] set_reg,
  input  logic       clr_en,
  input  logic [4:0] clr_reg,
  input  logic [4:0] rd_a_reg,
  input  logic [4:0] rd_b_reg,
  input  logic [4:0] waw_reg,
  output logic       a_busy,
  output logic       b_busy,
  output logic       waw_busy
);

  logic [31:0] pending_q;
  logic [31:0] pending_n;

  // Clear is applied before set so an issue and a writeback to the same
  // register in one cycle leaves the bit set for the new producer.
  always_comb begin
    pending_n = pending_q;
    if (clr_en) pending_n[clr_reg] = 1'b0;
    if (set_en) pending_n[set_reg] = 1'b1;
    pending_n[0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) pending_q <= '0;
    else       pending_q <= pending_n;
  end

  assign a_busy   = pending_q[rd_a_reg];
  assign b_busy   = pending_q[rd_b_reg];
  assign waw_busy = pending_q[waw_reg];

endmodule : issue_scoreboard

// File: rtl/issue_scheduler.sv
// ----------------------------------------------------------------------------
// issue_scheduler
// In-order issue stage. Holds decode while a source is pending (RAW), the
// destination is pending (WAW), or the single writeback port is already
// booked for the cycle this instruction would write back.
//
// Ports:
//   clock, reset                 clock and synchronous active-high reset
//   id_is_valid                  decode presents an instruction
//   id_is_functionalunit[1:0]    0 none, 1 X, 2 M, 3 Y
//   id_is_rega/regb[4:0]         source registers
//   id_is_regdest[4:0]           destination register
//   id_is_writereg               instruction writes regdest
//   wb_is_regdest[4:0]           register written back this cycle
//   wb_is_writereg               writeback valid this cycle
//   is_id_stall                  combinational hold back to decode
//   is_x/m/y_valid               registered one-hot issue strobes
//   is_regdest[4:0]              registered destination with the strobe
//   is_stall_count[31:0]         saturating count of stalled cycles
//
// Configuration:
//   ISSUE_WB_BYPASS_EN  when defined, a source being written back in the
//                       current cycle is treated as ready.
// ----------------------------------------------------------------------------
module issue_scheduler
  import issue_scheduler_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        id_is_valid,
  input  logic [1:0]  id_is_functionalunit,
  input  logic [4:0]  id_is_rega,
  input  logic [4:0]  id_is_regb,
  input  logic [4:0]  id_is_regdest,
  input  logic        id_is_writereg,
  input  logic [4:0]  wb_is_regdest,
  input  logic        wb_is_writereg,
  output logic        is_id_stall,
  output logic        is_x_valid,
  output logic        is_m_valid,
  output logic        is_y_valid,
  output logic [4:0]  is_regdest,
  output logic [31:0] is_stall_count
);

  fu_e         fu;
  logic        has_unit;
  logic        a_busy, b_busy, waw_busy;
  logic        raw_a, raw_b;
  logic        port_busy;
  logic        stall;
  logic        accept;
  logic        set_en;
  logic [RESV_DEPTH:1] resv_q;
  logic [RESV_DEPTH:1] resv_n;
  logic [RESV_DEPTH:1] book_vec;
  logic [31:0] stall_cnt_q;

  assign fu       = fu_e'(id_is_functionalunit);
  assign has_unit = (fu != FU_NONE);

  issue_scoreboard u_scoreboard (
    .clock    (clock),
    .reset    (reset),
    .set_en   (set_en),
    .set_reg  (id_is_regdest),
    .clr_en   (wb_is_writereg),
    .clr_reg  (wb_is_regdest),
    .rd_a_reg (id_is_rega),
    .rd_b_reg (id_is_regb),
    .waw_reg  (id_is_regdest),
    .a_busy   (a_busy),
    .b_busy   (b_busy),
    .waw_busy (waw_busy)
  );

  // Hazard detection. The bypass build lets a source being written back this
  // cycle through; otherwise it waits for its pending bit to clear.
  always_comb begin
    raw_a = a_busy;
    raw_b = b_busy;
`ifdef ISSUE_WB_BYPASS_EN
    if (wb_is_writereg && (wb_is_regdest == id_is_rega)) raw_a = 1'b0;
    if (wb_is_writereg && (wb_is_regdest == id_is_regb)) raw_b = 1'b0;
`endif

    // resv[k] books the writeback port k cycles ahead; look up our latency.
    port_busy = 1'b0;
    case (fu)
      FU_X:    port_busy = resv_q[LAT_X];
      FU_M:    port_busy = resv_q[LAT_M];
      FU_Y:    port_busy = resv_q[LAT_Y];
      default: port_busy = 1'b0;
    endcase

    stall = id_is_valid &
            (raw_a | raw_b |
             (id_is_writereg & waw_busy) |
             (id_is_writereg & has_unit & port_busy));
  end

  assign is_id_stall = stall;
  assign accept      = id_is_valid & ~stall;
  assign set_en      = accept & id_is_writereg & has_unit & (id_is_regdest != 5'd0);

  // The window shifts down one slot per cycle; a new issue books the slot
  // that will sit at index 0 exactly on its writeback cycle.
  always_comb begin
    book_vec = '0;
    if (accept && id_is_writereg) begin
      case (fu)
        FU_X:    book_vec[LAT_X-1] = 1'b1;
        FU_M:    book_vec[LAT_M-1] = 1'b1;
        FU_Y:    book_vec[LAT_Y-1] = 1'b1;
        default: book_vec = '0;
      endcase
    end
    resv_n = {1'b0, resv_q[RESV_DEPTH:2]} | book_vec;
  end

  // Registered state: reservation window, issue strobes and stall counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      resv_q      <= '0;
      is_x_valid  <= 1'b0;
      is_m_valid  <= 1'b0;
      is_y_valid  <= 1'b0;
      is_regdest  <= '0;
      stall_cnt_q <= '0;
    end else begin
      resv_q     <= resv_n;
      is_x_valid <= accept & (fu == FU_X);
      is_m_valid <= accept & (fu == FU_M);
      is_y_valid <= accept & (fu == FU_Y);
      if (accept && has_unit) is_regdest <= id_is_regdest;
      if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign is_stall_count = stall_cnt_q;

endmodule : issue_scheduler

// File: doc/issue_scheduler.md
ISSUE_SCHEDULER -- requirements
Module: issue_scheduler

Interface
REQ-001 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port id_is_valid  input  1  decode presents an instruction.
REQ-004 SHALL have port id_is_functionalunit  input  2  0=none, 1=X (ALU), 2=M (memory), 3=Y (multiply).
REQ-005 SHALL have port id_is_rega  input  5  source A register index.
REQ-006 SHALL have port id_is_regb  input  5  source B register index.
REQ-007 SHALL have port id_is_regdest  input  5  destination register index.
REQ-008 SHALL have port id_is_writereg  input  1  instruction writes regdest.
REQ-009 SHALL have port wb_is_regdest  input  5  register written back this cycle.
REQ-010 SHALL have port wb_is_writereg  input  1  writeback valid this cycle.
REQ-011 SHALL have port is_id_stall  output  1  combinational; instruction not accepted this cycle.
REQ-012 SHALL have port is_x_valid / is_m_valid / is_y_valid  output  1 each  registered one-hot issue strobe to the selected unit.
REQ-013 SHALL have port is_regdest  output  5  registered destination accompanying the issue strobe.
REQ-014 SHALL have port is_stall_count  output  32  saturating count of stalled cycles.

Function
REQ-015 SHALL define unit writeback latency L (issue-accept cycle to WB cycle): X=2, M=3, Y=5; unit 0 has no writeback.
REQ-016 SHALL hold a 32-bit pending bitmap; bit r set = outstanding write to r; bit 0 never set.
REQ-017 SHALL hold a 5-bit reservation vector resv[1..5]; resv[k]=1 means the single WB port is booked at cycle t+k.
REQ-018 SHALL assert is_id_stall when id_is_valid and any of: pending[rega], pending[regb] (RAW), id_is_writereg and pending[regdest] (WAW), id_is_writereg and unit!=0 and resv[L]=1 (WB-port conflict).
REQ-019 SHALL accept (issue) when id_is_valid and not is_id_stall; unit 0 accepts with no strobe and no booking.
REQ-020 SHALL update resv'[k] = resv[k+1] (resv[6]=0) OR (issue at t with writereg and L==k+1) each cycle.
REQ-021 SHALL on accepted issue with writereg and regdest!=0 set pending[regdest] next cycle.
REQ-022 SHALL on wb_is_writereg clear pending[wb_is_regdest] next cycle; on simultaneous set and clear of the same bit, set wins.
REQ-023 SHALL drive exactly one of is_x/m/y_valid high in the cycle after acceptance of unit 1/2/3, else all low.
REQ-024 SHALL increment is_stall_count each cycle is_id_stall=1, saturating at 32'hFFFFFFFF.
REQ-025 SHALL treat register 0 as always ready.

Reset
REQ-026 SHALL on reset clear pending, resv, is_x/m/y_valid, is_regdest, is_stall_count to 0.
REQ-027 SHALL treat reset as dominating: an issue or writeback in the reset cycle has no effect.
REQ-028 SHALL keep is_id_stall purely combinational; it reflects cleared state in the cycle after reset.

Configuration
REQ-029 SHALL, with ISSUE_WB_BYPASS_EN defined, treat a source equal to wb_is_regdest with wb_is_writereg=1 as ready in that cycle (RAW stall removed).
REQ-030 SHALL, without ISSUE_WB_BYPASS_EN, stall such a source one extra cycle until pending bit clears; WAW and port checks unchanged in both builds.

Structure
REQ-031 SHALL place functional-unit encodings and latency constants (LAT_X, LAT_M, LAT_Y) in a shared package used by issue and execute stages.
REQ-032 SHALL implement the pending bitmap as sub-module issue_scoreboard (set, clear, two read ports, one WAW read port); resv logic stays in the top.

Verification
REQ-033 SHALL check: Y issue r5, next cycle X reads r5 -> is_id_stall=1 until WB r5 cycle (bypass build: released that cycle; non-bypass: one cycle later).
REQ-034 SHALL check: Y issue (L=5) at t, X issue at t+3 (L=2, booking t+5) -> stall at t+3, accepted t+4.
REQ-035 SHALL check: X writes r3 then M writes r3 back-to-back -> WAW stall on M until r3 written back.
REQ-036 SHALL check: issue writing r0 -> pending stays 0, later reader of r0 never stalls.
REQ-037 SHALL check: reset asserted while Y op in flight -> pending=0, resv=0, is_stall_count=0 next cycle, immediate new issue accepted.
REQ-038 SHALL check: force stall for 2^32 cycles (preloaded counter 32'hFFFFFFFE) -> count saturates at 32'hFFFFFFFF.
